// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch/sequencing controller:
// fetch-state encoding (also decoded by the datapath) and opcode constants.
package instr_fetch_seq_pkg;

    // 4-bit encoding so the datapath can compare current_state directly
    typedef enum logic [3:0] {
        STATE_HLT   = 4'd0,
        STATE_FETCH = 4'd1,
        STATE_EXEC  = 4'd2
    } fetch_state_t;

    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam logic [31:0] RETIRED_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == RETIRED_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/sequencing controller: fetches words over a req/ack port,
// presents them on instr0 for one EXEC cycle, and owns PC, halt/stop and retire count.
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
#(
    parameter int                    PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_pc,
    input  logic                 stop,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_ack,
    input  logic                 jump_en,
    input  logic [PC_WIDTH-1:0]  jump_pc,
    output logic [31:0]          instr0,
    output logic [3:0]           current_state,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 halted,
    output logic [31:0]          retired
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_t          state_reg, state_next;
    logic [PC_WIDTH-1:0]   pc_reg, pc_next;
    logic [31:0]           instr_reg, instr_next;
    logic [31:0]           retired_reg, retired_next;
    logic                  stop_pend_reg, stop_pend_next;
    logic                  halted_reg, halted_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= STATE_HLT;
            pc_reg        <= RESET_PC;
            instr_reg     <= '0;
            retired_reg   <= '0;
            stop_pend_reg <= 1'b0;
            halted_reg    <= 1'b1;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            instr_reg     <= instr_next;
            retired_reg   <= retired_next;
            stop_pend_reg <= stop_pend_next;
            halted_reg    <= halted_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        instr_next     = instr_reg;
        retired_next   = retired_reg;
        stop_pend_next = stop_pend_reg;

        case (state_reg)
            STATE_HLT: begin
                if (start) begin
                    pc_next    = start_pc;
                    state_next = STATE_FETCH;
                end
            end
            STATE_FETCH: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = STATE_EXEC;
                end
            end
            STATE_EXEC: begin
                // HALT leaves pc pointing at itself and is not counted as retired
                if (instr_reg[31:24] == OP_HALT) begin
                    state_next = STATE_HLT;
                end else begin
                    pc_next      = jump_en ? jump_pc : pc_reg + PC_ONE;
                    retired_next = sat_inc32(retired_reg);
                    state_next   = (stop_pend_reg || stop) ? STATE_HLT : STATE_FETCH;
                end
            end
            default: begin
                state_next = STATE_HLT;
            end
        endcase

        // A pending stop survives until the controller actually reaches HLT
        if (state_next == STATE_HLT) begin
            stop_pend_next = 1'b0;
        end else if (state_reg != STATE_HLT && stop) begin
            stop_pend_next = 1'b1;
        end

        halted_next = (state_next == STATE_HLT);
    end

    // Decoded from the state register so an async reset drops the request at once
    assign imem_req      = (state_reg == STATE_FETCH);
    assign imem_addr     = pc_reg;
    assign pc            = pc_reg;
    assign instr0        = instr_reg;
    assign current_state = state_reg;
    assign halted        = halted_reg;
    assign retired       = retired_reg;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed scenarios plus a randomized
// instruction stream checked against a per-instruction reference model.
module tb_instr_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_pc = '0;
    logic        stop = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        jump_en = 1'b0;
    logic [15:0] jump_pc = '0;
    logic [31:0] instr0;
    logic [3:0]  current_state;
    logic [15:0] pc;
    logic        halted;
    logic [31:0] retired;

    int vectors = 0;
    int errors  = 0;

    // Reference model: architectural state after each whole instruction
    logic [15:0] m_pc;
    logic [31:0] m_retired;
    logic        m_halted;
    logic [31:0] m_instr;

    instr_fetch_seq #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .stop(stop),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .jump_en(jump_en), .jump_pc(jump_pc),
        .instr0(instr0), .current_state(current_state), .pc(pc),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_nop_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:24] == 8'hFF) w[31:24] = 8'h01;
        return w;
    endfunction

    task automatic model_reset;
        m_pc = 16'h0000; m_retired = 32'd0; m_halted = 1'b1; m_instr = 32'd0;
    endtask

    task automatic do_start(input logic [15:0] spc, input logic with_stop);
        vectors++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || current_state !== 4'd0) begin
            errors++;
            $display("FAIL hlt_idle: halted=%b req=%b state=%0d, required halted=1 req=0 state=0",
                     halted, imem_req, current_state);
        end
        start = 1'b1; start_pc = spc; stop = with_stop;
        tick;
        start = 1'b0; stop = 1'b0; start_pc = 16'($urandom);
        m_pc = spc; m_halted = 1'b0;
        vectors++;
        if (current_state !== 4'd1 || pc !== m_pc || halted !== 1'b0) begin
            errors++;
            $display("FAIL start: state=%0d pc=%h halted=%b, required state=1 pc=%h halted=0",
                     current_state, pc, halted, m_pc);
        end
        $display("start   pc=%h stop=%b", spc, with_stop);
    endtask

    // One full instruction: wait_n stall cycles then ack, EXEC, then model update + checks
    task automatic do_instr(input int wait_n, input logic [31:0] word, input logic jmp,
                            input logic [15:0] jpc, input int stop_at, input logic stop_exec);
        logic pend;
        pend = 1'b0;
        for (int i = 0; i <= wait_n; i++) begin
            vectors++;
            if (current_state !== 4'd1 || imem_req !== 1'b1 || imem_addr !== m_pc || instr0 !== m_instr) begin
                errors++;
                $display("FAIL fetch: state=%0d req=%b addr=%h instr0=%h, required state=1 req=1 addr=%h instr0=%h",
                         current_state, imem_req, imem_addr, instr0, m_pc, m_instr);
            end
            imem_ack   = (i == wait_n);
            imem_rdata = (i == wait_n) ? word : $urandom;
            stop       = (i == stop_at);
            if (stop) pend = 1'b1;
            jump_en = 1'($urandom);
            jump_pc = 16'($urandom);
            tick;
        end
        imem_ack = 1'b0; stop = 1'b0;
        m_instr = word;
        vectors++;
        if (current_state !== 4'd2 || imem_req !== 1'b0 || instr0 !== word || pc !== m_pc || halted !== 1'b0) begin
            errors++;
            $display("FAIL exec: state=%0d req=%b instr0=%h pc=%h halted=%b, required state=2 req=0 instr0=%h pc=%h halted=0",
                     current_state, imem_req, instr0, pc, halted, word, m_pc);
        end
        jump_en = jmp; jump_pc = jpc; stop = stop_exec;
        imem_ack = 1'($urandom); imem_rdata = $urandom;
        tick;
        jump_en = 1'b0; stop = 1'b0; imem_ack = 1'b0;

        if (word[31:24] == 8'hFF) begin
            m_halted = 1'b1;
        end else begin
            m_pc = jmp ? jpc : m_pc + 16'd1;
            if (m_retired != 32'hFFFF_FFFF) m_retired = m_retired + 32'd1;
            m_halted = pend | stop_exec;
        end
        vectors++;
        if (current_state !== (m_halted ? 4'd0 : 4'd1) || pc !== m_pc || retired !== m_retired ||
            halted !== m_halted || imem_req !== !m_halted) begin
            errors++;
            $display("FAIL after_exec: state=%0d pc=%h retired=%0d halted=%b req=%b, required state=%0d pc=%h retired=%0d halted=%b req=%b",
                     current_state, pc, retired, halted, imem_req, m_halted ? 0 : 1, m_pc, m_retired, m_halted, !m_halted);
        end
        $display("instr   word=%h wait=%0d jmp=%b stop=%b -> pc=%h retired=%0d halted=%b",
                 word, wait_n, jmp, pend | stop_exec, m_pc, m_retired, m_halted);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        vectors++;
        if (current_state !== 4'd0 || pc !== 16'h0000 || instr0 !== 32'd0 || imem_req !== 1'b0 ||
            halted !== 1'b1 || retired !== 32'd0) begin
            errors++;
            $display("FAIL reset: state=%0d pc=%h instr0=%h req=%b halted=%b retired=%0d, required 0/0000/0/0/1/0",
                     current_state, pc, instr0, imem_req, halted, retired);
        end
        rst_n = 1'b1;
        model_reset();
        $display("reset   checked");
    endtask

    task automatic test_zero_wait;
        do_start(16'h0010, 1'b0);
        do_instr(0, rand_nop_word(), 1'b0, 16'h0, -1, 1'b0);
        do_instr(0, rand_nop_word(), 1'b0, 16'h0, -1, 1'b0);
    endtask

    task automatic test_ack_delay;
        do_instr(3, rand_nop_word(), 1'b0, 16'h0, -1, 1'b0);
    endtask

    task automatic test_jump;
        do_instr(0, rand_nop_word(), 1'b1, 16'h0100, -1, 1'b0);
        do_instr(1, rand_nop_word(), 1'b1, 16'h0005, -1, 1'b0);
    endtask

    task automatic test_halt_op;
        do_instr(1, 32'hFF00_0000, 1'b0, 16'h0, -1, 1'b0);
        // HLT must ignore stray acks and jumps
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = $urandom; jump_en = 1'b1; jump_pc = 16'($urandom);
            tick;
            vectors++;
            if (current_state !== 4'd0 || pc !== 16'h0005 || instr0 !== 32'hFF00_0000 || retired !== m_retired) begin
                errors++;
                $display("FAIL hlt_hold: state=%0d pc=%h instr0=%h retired=%0d, required state=0 pc=0005 instr0=ff000000 retired=%0d",
                         current_state, pc, instr0, retired, m_retired);
            end
        end
        imem_ack = 1'b0; jump_en = 1'b0;
    endtask

    task automatic test_stop;
        do_start(16'h0040, 1'b1);
        do_instr(0, rand_nop_word(), 1'b0, 16'h0, -1, 1'b0);
        do_instr(2, rand_nop_word(), 1'b0, 16'h0, 0, 1'b0);
    endtask

    task automatic test_wrap_and_reset;
        do_start(16'hFFFF, 1'b0);
        do_instr(0, rand_nop_word(), 1'b0, 16'h0, -1, 1'b0);
        // Now fetching at 0x0000: stall one cycle, then reset mid-fetch
        imem_ack = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b0 || current_state !== 4'd0 || halted !== 1'b1 || retired !== 32'd0 || instr0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_fetch: req=%b state=%0d halted=%b retired=%0d instr0=%h, required 0/0/1/0/0",
                     imem_req, current_state, halted, retired, instr0);
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick;
        rst_n = 1'b1;
        tick;
        imem_ack = 1'b0;
        vectors++;
        if (current_state !== 4'd0 || instr0 !== 32'd0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: state=%0d instr0=%h req=%b, required state=0 instr0=0 req=0",
                     current_state, instr0, imem_req);
        end
        model_reset();
        $display("reset   mid-fetch checked");
    endtask

    task automatic test_random;
        logic [31:0] w;
        for (int n = 0; n < 60; n++) begin
            if (m_halted) do_start(16'($urandom), 1'($urandom));
            w = ($urandom_range(0, 7) == 0) ? {8'hFF, 24'($urandom)} : rand_nop_word();
            do_instr($urandom_range(0, 3), w, 1'($urandom), 16'($urandom),
                     ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1,
                     ($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_ack_delay();
        test_jump();
        test_halt_op();
        test_stop();
        test_wrap_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
